// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - IEEE 1149.1 TAP FSM with IR, BYPASS, USER and BSR data registers
// Optional feature macro: JTAG_IDCODE_EN (adds IDCODE opcode 2 with a 32-bit DR)
module jtag_tap_controller #(
    parameter int IR_WIDTH          = 5,
    parameter int TEST_VECTOR_WIDTH = 32,
    parameter int BSR_WIDTH         = 62
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tms,
    input  logic                         tdi,
    input  logic [TEST_VECTOR_WIDTH-1:0] userDataIn,
    input  logic [BSR_WIDTH-1:0]         bsrDataIn,
    output logic                         tdo,
    output logic                         tdoValid,
    output logic [3:0]                   tapState,
    output logic [IR_WIDTH-1:0]          irValue,
    output logic [TEST_VECTOR_WIDTH-1:0] userDataOut,
    output logic [BSR_WIDTH-1:0]         bsrDataOut,
    output logic                         updateDrPulse
);

    typedef enum logic [3:0] {
        ST_RESET      = 4'd0,
        ST_IDLE       = 4'd1,
        ST_DR_SCAN    = 4'd2,
        ST_IR_SCAN    = 4'd3,
        ST_CAPTURE_IR = 4'd4,
        ST_SHIFT_IR   = 4'd5,
        ST_EXIT1_IR   = 4'd6,
        ST_PAUSE_IR   = 4'd7,
        ST_EXIT2_IR   = 4'd8,
        ST_UPDATE_IR  = 4'd9,
        ST_CAPTURE_DR = 4'd10,
        ST_SHIFT_DR   = 4'd11,
        ST_EXIT1_DR   = 4'd12,
        ST_PAUSE_DR   = 4'd13,
        ST_EXIT2_DR   = 4'd14,
        ST_UPDATE_DR  = 4'd15
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(0);
    localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_BSR    = IR_WIDTH'(6);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_DEFAULT = OP_IDCODE;
    localparam logic [31:0]         IDCODE_VALUE = 32'h1234_5ACF;
`else
    localparam logic [IR_WIDTH-1:0] IR_DEFAULT = OP_BYPASS;
`endif

    tap_state_e                   state_q, state_d;
    logic [IR_WIDTH-1:0]          ir_shift_q, ir_value_q;
    logic                         bypass_q;
    logic [TEST_VECTOR_WIDTH-1:0] user_shift_q, user_out_q;
    logic [BSR_WIDTH-1:0]         bsr_shift_q, bsr_out_q;
    logic                         upd_pulse_q;
    logic                         sel_user, sel_bsr, sel_idcode;

    // Instruction decode; every unlisted opcode falls through to BYPASS
    assign sel_user = (ir_value_q == OP_USER);
    assign sel_bsr  = (ir_value_q == OP_BSR);
`ifdef JTAG_IDCODE_EN
    assign sel_idcode = (ir_value_q == OP_IDCODE);
    logic [31:0] idcode_shift_q;

    // IDCODE DR: loads the fixed device ID on capture, shifts LSB-first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idcode_shift_q <= '0;
        end else if (sel_idcode && state_q == ST_CAPTURE_DR) begin
            idcode_shift_q <= IDCODE_VALUE;
        end else if (sel_idcode && state_q == ST_SHIFT_DR) begin
            idcode_shift_q <= {tdi, idcode_shift_q[31:1]};
        end
    end
`else
    assign sel_idcode = 1'b0;
`endif

    // TAP state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    // TAP next-state decode from tms
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:      state_d = tms ? ST_RESET      : ST_IDLE;
            ST_IDLE:       state_d = tms ? ST_DR_SCAN    : ST_IDLE;
            ST_DR_SCAN:    state_d = tms ? ST_IR_SCAN    : ST_CAPTURE_DR;
            ST_IR_SCAN:    state_d = tms ? ST_RESET      : ST_CAPTURE_IR;
            ST_CAPTURE_IR: state_d = tms ? ST_EXIT1_IR   : ST_SHIFT_IR;
            ST_SHIFT_IR:   state_d = tms ? ST_EXIT1_IR   : ST_SHIFT_IR;
            ST_EXIT1_IR:   state_d = tms ? ST_UPDATE_IR  : ST_PAUSE_IR;
            ST_PAUSE_IR:   state_d = tms ? ST_EXIT2_IR   : ST_PAUSE_IR;
            ST_EXIT2_IR:   state_d = tms ? ST_UPDATE_IR  : ST_SHIFT_IR;
            ST_UPDATE_IR:  state_d = tms ? ST_DR_SCAN    : ST_IDLE;
            ST_CAPTURE_DR: state_d = tms ? ST_EXIT1_DR   : ST_SHIFT_DR;
            ST_SHIFT_DR:   state_d = tms ? ST_EXIT1_DR   : ST_SHIFT_DR;
            ST_EXIT1_DR:   state_d = tms ? ST_UPDATE_DR  : ST_PAUSE_DR;
            ST_PAUSE_DR:   state_d = tms ? ST_EXIT2_DR   : ST_PAUSE_DR;
            ST_EXIT2_DR:   state_d = tms ? ST_UPDATE_DR  : ST_SHIFT_DR;
            ST_UPDATE_DR:  state_d = tms ? ST_DR_SCAN    : ST_IDLE;
            default:       state_d = ST_RESET;
        endcase
    end

    // IR shift path: capture the 01 pattern, shift LSB-first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_shift_q <= '0;
        end else if (state_q == ST_CAPTURE_IR) begin
            ir_shift_q <= IR_WIDTH'(1);
        end else if (state_q == ST_SHIFT_IR) begin
            ir_shift_q <= (ir_shift_q >> 1) | (IR_WIDTH'(tdi) << (IR_WIDTH - 1));
        end
    end

    // Active instruction: loaded in Update-IR, forced to default in Test-Logic-Reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_value_q <= IR_DEFAULT;
        end else if (state_q == ST_RESET) begin
            ir_value_q <= IR_DEFAULT;
        end else if (state_q == ST_UPDATE_IR) begin
            ir_value_q <= ir_shift_q;
        end
    end

    // Data shift registers: only the selected DR captures or shifts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bypass_q     <= 1'b0;
            user_shift_q <= '0;
            bsr_shift_q  <= '0;
        end else if (state_q == ST_CAPTURE_DR) begin
            if (sel_user)                             user_shift_q <= userDataIn;
            else if (sel_bsr)                         bsr_shift_q  <= bsrDataIn;
            else if (!sel_idcode)                     bypass_q     <= 1'b0;
        end else if (state_q == ST_SHIFT_DR) begin
            if (sel_user)
                user_shift_q <= (user_shift_q >> 1) | (TEST_VECTOR_WIDTH'(tdi) << (TEST_VECTOR_WIDTH - 1));
            else if (sel_bsr)
                bsr_shift_q <= (bsr_shift_q >> 1) | (BSR_WIDTH'(tdi) << (BSR_WIDTH - 1));
            else if (!sel_idcode)
                bypass_q <= tdi;
        end
    end

    // Parallel DR outputs latched in Update-DR, plus the one-cycle update strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            user_out_q  <= '0;
            bsr_out_q   <= '0;
            upd_pulse_q <= 1'b0;
        end else begin
            upd_pulse_q <= (state_q == ST_UPDATE_DR);
            if (state_q == ST_UPDATE_DR && sel_user) user_out_q <= user_shift_q;
            if (state_q == ST_UPDATE_DR && sel_bsr)  bsr_out_q  <= bsr_shift_q;
        end
    end

    // Serial output mux: bit0 of the active shift path, quiet outside shift states
    always_comb begin
        tdo      = 1'b0;
        tdoValid = 1'b0;
        if (state_q == ST_SHIFT_IR) begin
            tdoValid = 1'b1;
            tdo      = ir_shift_q[0];
        end else if (state_q == ST_SHIFT_DR) begin
            tdoValid = 1'b1;
            if (sel_user)     tdo = user_shift_q[0];
            else if (sel_bsr) tdo = bsr_shift_q[0];
`ifdef JTAG_IDCODE_EN
            else if (sel_idcode) tdo = idcode_shift_q[0];
`endif
            else              tdo = bypass_q;
        end
    end

    assign tapState      = state_q;
    assign irValue       = ir_value_q;
    assign userDataOut   = user_out_q;
    assign bsrDataOut    = bsr_out_q;
    assign updateDrPulse = upd_pulse_q;

endmodule
